fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the IF stage. Owns the program counter, issues one-outstanding-request fetches to instruction memory over a valid/ready handshake, and presents fetched instructions to the IF/ID register. Applies hazard-unit stalls, branch/jump redirects from EX and trap redirects, and discards in-flight responses made stale by a redirect.

## Interface
- `RESET_PC`, 32'h0000_0400: PC value after reset.
- `TRAP_VEC`, 32'h0000_0200: PC loaded on trap or misaligned redirect.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts request this cycle.
- `imem_addr` output 32: fetch address; equals the current PC.
- `imem_resp_valid` input 1: response data valid.
- `imem_resp_data` input 32: fetched instruction.
- `stall` input 1: hazard unit; IF/ID cannot accept.
- `redirect_valid` input 1: branch/jump taken in EX.
- `redirect_pc` input 32: redirect target.
- `trap` input 1: exception; redirect to `TRAP_VEC`.
- `if_valid` output 1: `if_pc`/`if_instr` hold a valid instruction.
- `if_pc` output 32: PC of the presented instruction.
- `if_instr` output 32: presented instruction.
- `misaligned` output 1: one-cycle pulse; redirect target not word-aligned.

## Operation
- States: IDLE, REQ, RESP, HOLD. Exactly one request outstanding.
- IDLE: entered on reset; `imem_req_valid`=0. Next edge goes to REQ.
- REQ: `imem_req_valid`=1, `imem_addr`=PC. `imem_req_ready`=1 goes to RESP.
- RESP: waits for `imem_resp_valid`. On response, capture `if_instr`←data and `if_pc`←PC, set `if_valid`, and go to HOLD.
- HOLD: `if_valid`=1. Transfer completes at an edge with `stall`=0. Then PC←PC+4, `if_valid`←0, and go to REQ. While `stall`=1, all outputs hold.
- Redirect priority: trap > redirect_valid > stall > normal flow. A redirect overrides stall.
- Trap or redirect, in any state except IDLE:
  - Sets PC←`TRAP_VEC` for a trap, or PC←`redirect_pc` for a redirect.
  - Clears `if_valid`.
- Redirect state transitions:
  - From REQ with ready=0: go to REQ, with the new address on the next cycle. The unaccepted request is abandoned.
  - From REQ with ready=1 in the same cycle, or from RESP: set the `drop` flag and go to RESP. The next response is discarded, then the controller goes to REQ.
  - From HOLD: go to REQ.
- `drop` with a redirect in the same cycle as the stale response: the response is discarded, `drop` stays set for one more response only if a new request was accepted.
- Misaligned redirect (`redirect_pc[1:0]`≠0 with `redirect_valid`=1 and `trap`=0):
  - Behaves as a trap to `TRAP_VEC`.
  - `misaligned` pulses high for 1 cycle.
- PC arithmetic is 32-bit unsigned. PC+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).

## Timing
- Reset values:
  - State: IDLE.
  - PC: `RESET_PC`.
  - `imem_req_valid`: 0.
  - `imem_addr`: 0x400.
  - `if_valid`: 0.
  - `if_pc`: 0.
  - `if_instr`: 32'h0000_0013 (NOP).
  - `misaligned`: 0.
  - `drop`: 0.
- Reset deassertion: first request on cycle 2 after reset releases (IDLE, then REQ).
- Best case (ready=1, response 1 cycle after accept, stall=0): one instruction per 3 cycles (REQ, RESP, HOLD).
- Redirect to new request: the new address appears on `imem_addr` the cycle after the redirect edge.
- All outputs are registered, except `imem_addr`, which is a direct copy of the PC register.
- Reset asserted mid-operation: immediate async return to reset values. Any outstanding response is ignored by virtue of IDLE.

## Structure
- Shared package `riscv_pkg`:
  - State enum.
  - `NOP_INSTR` (32'h0000_0013).
  - Default `RESET_PC`/`TRAP_VEC` constants.
- Sub-module `fetch_pc_reg`: 32-bit PC register with load enable. Async active-low reset to `RESET_PC`. Next-PC select (PC+4 / redirect / trap vector) stays in `fetch_ctrl`.

## Test plan
- Reset then free-run: ready=1, 1-cycle response, stall=0 → requests at 0x400, 0x404, 0x408 every 3 cycles; `if_pc` follows each with `if_valid`.
- Stall: `stall`=1 for 4 cycles in HOLD at 0x404 → `if_valid`/`if_pc`/`if_instr` constant; no new request until stall drops; next request 0x408.
- Stale response: redirect to 0x800 while in RESP for 0x408 → 0x408 response discarded (`if_valid` stays 0); next request 0x800; `if_pc`=0x800 delivered.
- Trap vs redirect: `trap`=1 and `redirect_valid`=1 (0x900) in the same cycle → next request 0x200.
- Misaligned: redirect to 0x802 → `misaligned` pulses 1 cycle; next request 0x200.
- Async reset mid-RESP → outputs take reset values immediately; the late response is ignored; fetch restarts at 0x400.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM states,
// the canonical NOP encoding and the default reset/trap addresses.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0400;
    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0200;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter storage with a load enable; the next-PC choice is made
// by the fetch controller.
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] pc_next,
    output logic [31:0] pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding instruction-memory request,
// stall handling, branch/trap redirects and discard of stale responses.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misaligned
);

    fetch_state_t state, state_n;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        drop, drop_n;
    logic        if_valid_n;
    logic [31:0] if_pc_n;
    logic [31:0] if_instr_n;
    logic        misaligned_n;

    logic        redir_any;
    logic        bad_align;
    logic [31:0] redir_target;

    // A misaligned branch target is treated exactly like a trap.
    assign bad_align    = redirect_valid && !trap && !is_word_aligned(redirect_pc);
    assign redir_any    = trap || redirect_valid;
    assign redir_target = (trap || bad_align) ? TRAP_VEC : redirect_pc;
    assign imem_addr    = pc;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock   (clock),
        .reset   (reset),
        .load    (pc_load),
        .pc_next (pc_next),
        .pc      (pc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            imem_req_valid <= 1'b0;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0000_0000;
            if_instr       <= NOP_INSTR;
            misaligned     <= 1'b0;
            drop           <= 1'b0;
        end else begin
            state          <= state_n;
            imem_req_valid <= (state_n == S_REQ);
            if_valid       <= if_valid_n;
            if_pc          <= if_pc_n;
            if_instr       <= if_instr_n;
            misaligned     <= misaligned_n;
            drop           <= drop_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_load      = 1'b0;
        pc_next      = pc + 32'd4;
        drop_n       = drop;
        if_valid_n   = if_valid;
        if_pc_n      = if_pc;
        if_instr_n   = if_instr;
        misaligned_n = 1'b0;

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
            end

            S_REQ: begin
                if (redir_any) begin
                    pc_load      = 1'b1;
                    pc_next      = redir_target;
                    if_valid_n   = 1'b0;
                    misaligned_n = bad_align;
                    // An accepted request still owes us a response that must be thrown away.
                    if (imem_req_ready) begin
                        drop_n  = 1'b1;
                        state_n = S_RESP;
                    end else begin
                        state_n = S_REQ;
                    end
                end else if (imem_req_ready) begin
                    state_n = S_RESP;
                end
            end

            S_RESP: begin
                if (redir_any) begin
                    pc_load      = 1'b1;
                    pc_next      = redir_target;
                    if_valid_n   = 1'b0;
                    misaligned_n = bad_align;
                    if (imem_resp_valid) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        drop_n  = 1'b1;
                        state_n = S_RESP;
                    end
                end else if (imem_resp_valid) begin
                    if (drop) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                    end else begin
                        if_valid_n = 1'b1;
                        if_pc_n    = pc;
                        if_instr_n = imem_resp_data;
                        state_n    = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (redir_any) begin
                    pc_load      = 1'b1;
                    pc_next      = redir_target;
                    if_valid_n   = 1'b0;
                    misaligned_n = bad_align;
                    state_n      = S_REQ;
                end else if (!stall) begin
                    pc_load    = 1'b1;
                    if_valid_n = 1'b0;
                    state_n    = S_REQ;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with a one-outstanding memory
// model that answers one cycle after accept unless a row holds it back.
module tb_fetch_ctrl;

    typedef struct {
        logic        ready;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        trap;
        logic        hold_resp;
        logic        e_rq;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misaligned;

    int total;
    int bad;

    logic        pending;
    logic [31:0] pend_addr;

    vec_t vecs[$];

    fetch_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .trap            (trap),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .misaligned      (misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(
        input logic ready, input logic stl, input logic rv, input logic [31:0] rpc,
        input logic trp, input logic hold,
        input logic e_rq, input logic [31:0] e_addr, input logic e_iv,
        input logic [31:0] e_ifpc, input logic [31:0] e_instr, input logic e_mis);
        vec_t v;
        v.ready = ready; v.stall = stl; v.rv = rv; v.rpc = rpc; v.trap = trp;
        v.hold_resp = hold; v.e_rq = e_rq; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_ifpc = e_ifpc; v.e_instr = e_instr; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic compare(input string tag, input string field,
                           input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s %s actual=%h required=%h", tag, field, actual, required);
        end
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        compare(tag, "imem_req_valid", {31'd0, imem_req_valid}, {31'd0, v.e_rq});
        compare(tag, "imem_addr", imem_addr, v.e_addr);
        compare(tag, "if_valid", {31'd0, if_valid}, {31'd0, v.e_iv});
        compare(tag, "if_pc", if_pc, v.e_ifpc);
        compare(tag, "if_instr", if_instr, v.e_instr);
        compare(tag, "misaligned", {31'd0, misaligned}, {31'd0, v.e_mis});
    endtask

    // Drives one cycle of inputs, lets the edge happen, and advances the memory model.
    task automatic applyStimulus(input vec_t v);
        logic        acc;
        logic [31:0] acc_addr;
        logic        delivered;
        imem_req_ready  = v.ready;
        stall           = v.stall;
        redirect_valid  = v.rv;
        redirect_pc     = v.rpc;
        trap            = v.trap;
        imem_resp_valid = pending && !v.hold_resp;
        imem_resp_data  = pending ? (pend_addr ^ 32'h00AB_0000) : 32'hDEAD_BEEF;
        acc       = imem_req_valid && imem_req_ready;
        acc_addr  = imem_addr;
        delivered = imem_resp_valid;
        @(posedge clock);
        if (delivered) pending = 1'b0;
        if (acc) begin
            pending   = 1'b1;
            pend_addr = acc_addr;
        end
        #1;
    endtask

    initial begin
        vec_t rst_v;
        vec_t v;
        total = 0;
        bad = 0;
        pending = 1'b0;
        pend_addr = 32'h0;
        reset = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'h0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        trap = 1'b0;

        rst_v = mk(1, 0, 0, 0, 0, 0, 0, 32'h400, 0, 32'h0, 32'h0000_0013, 0);

        // free run
        vecs.push_back(mk(1,0,0,32'h0,0,0, 1,32'h400,0,32'h0,32'h0000_0013,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h400,0,32'h0,32'h0000_0013,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h400,1,32'h400,32'h00AB_0400,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 1,32'h404,0,32'h400,32'h00AB_0400,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h404,0,32'h400,32'h00AB_0400,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h404,1,32'h404,32'h00AB_0404,0));
        // stall four cycles in HOLD
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,1,0,32'h0,0,0, 0,32'h404,1,32'h404,32'h00AB_0404,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 1,32'h408,0,32'h404,32'h00AB_0404,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h408,0,32'h404,32'h00AB_0404,0));
        // redirect in RESP, stale 0x408 response arrives a cycle later
        vecs.push_back(mk(1,0,1,32'h800,0,1, 0,32'h800,0,32'h404,32'h00AB_0404,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 1,32'h800,0,32'h404,32'h00AB_0404,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h800,0,32'h404,32'h00AB_0404,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h800,1,32'h800,32'h00AB_0800,0));
        // trap beats redirect
        vecs.push_back(mk(1,0,1,32'h900,1,0, 1,32'h200,0,32'h800,32'h00AB_0800,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h200,0,32'h800,32'h00AB_0800,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h200,1,32'h200,32'h00AB_0200,0));
        // misaligned redirect
        vecs.push_back(mk(1,0,1,32'h802,0,0, 1,32'h200,0,32'h200,32'h00AB_0200,1));
        vecs.push_back(mk(0,0,0,32'h0,0,0, 1,32'h200,0,32'h200,32'h00AB_0200,0));
        // redirect while REQ not accepted, then PC wrap
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0, 1,32'hFFFF_FFFC,0,32'h200,32'h00AB_0200,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'hFFFF_FFFC,0,32'h200,32'h00AB_0200,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'hFF54_FFFC,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 1,32'h0,0,32'hFFFF_FFFC,32'hFF54_FFFC,0));
        // redirect in the same cycle a request is accepted
        vecs.push_back(mk(1,0,1,32'h300,0,0, 0,32'h300,0,32'hFFFF_FFFC,32'hFF54_FFFC,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 1,32'h300,0,32'hFFFF_FFFC,32'hFF54_FFFC,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h300,0,32'hFFFF_FFFC,32'hFF54_FFFC,0));
        vecs.push_back(mk(1,0,0,32'h0,0,0, 0,32'h300,1,32'h300,32'h00AB_0300,0));

        #12;
        checkOutput(rst_v, "reset");
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("row%0d", i));
        end

        // async reset while a response is outstanding
        v = mk(1,0,0,32'h0,0,0, 1,32'h304,0,32'h300,32'h00AB_0300,0);
        applyStimulus(v);
        checkOutput(v, "pre_rst_req");
        v = mk(1,0,0,32'h0,0,0, 0,32'h304,0,32'h300,32'h00AB_0300,0);
        applyStimulus(v);
        checkOutput(v, "pre_rst_resp");
        #2;
        reset = 1'b0;
        #1;
        checkOutput(rst_v, "async_rst");
        applyStimulus(rst_v);
        checkOutput(rst_v, "late_resp");
        reset = 1'b1;
        v = mk(1,0,0,32'h0,0,0, 1,32'h400,0,32'h0,32'h0000_0013,0);
        applyStimulus(v);
        checkOutput(v, "restart_req");
        v = mk(1,0,0,32'h0,0,0, 0,32'h400,0,32'h0,32'h0000_0013,0);
        applyStimulus(v);
        checkOutput(v, "restart_resp");
        v = mk(1,0,0,32'h0,0,0, 0,32'h400,1,32'h400,32'h00AB_0400,0);
        applyStimulus(v);
        checkOutput(v, "restart_hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
